// File: rtl/regfile_2r1w_param.sv
// Parametrised 2-read/1-write register file with registered reads, optional
// write bypass, optional hardwired-zero entry 0, post-reset clear sequencer and debug probe.
module regfile_2r1w_param #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 4,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] dir_a_i,
  input  logic [ADDR_W-1:0] dir_b_i,
  input  logic              re_a_n_i,
  input  logic              re_b_n_i,
  input  logic [ADDR_W-1:0] dir_wr_i,
  input  logic [WIDTH-1:0]  di_i,
  input  logic              we_n_i,
  input  logic [ADDR_W-1:0] probe_sel_i,
  output logic [WIDTH-1:0]  data_a_o,
  output logic [WIDTH-1:0]  data_b_o,
  output logic [WIDTH-1:0]  probe_o,
  output logic              busy_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W:0]    cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   data_a_q, data_a_d;
  logic [WIDTH-1:0]   data_b_q, data_b_d;
  logic [WIDTH-1:0]   probe_q, probe_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];

  logic               wr_ok;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [WIDTH-1:0]   mem_wdata;

  // Read-port priority: disabled, hardwired zero, bypass, stored value.
  function automatic logic [WIDTH-1:0] read_word(
    input logic              re_n,
    input logic [ADDR_W-1:0] addr,
    input logic [WIDTH-1:0]  stored,
    input logic              wok,
    input logic [ADDR_W-1:0] waddr,
    input logic [WIDTH-1:0]  wdata
  );
    if (re_n)
      return '1;
    else if ((ZERO_REG != 0) && (addr == '0))
      return '0;
    else if ((BYPASS != 0) && wok && (waddr == addr))
      return wdata;
    else
      return stored;
  endfunction

  assign wr_ok = !we_n_i && !((ZERO_REG != 0) && (dir_wr_i == '0));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    data_a_d  = '1;
    data_b_d  = '1;
    probe_d   = '1;
    mem_we    = 1'b0;
    mem_waddr = dir_wr_i;
    mem_wdata = di_i;
    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q[ADDR_W-1:0];
      mem_wdata = '0;
      cnt_d     = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = S_READY;
        busy_d  = 1'b0;
      end
    end else begin
      mem_we   = wr_ok;
      data_a_d = read_word(re_a_n_i, dir_a_i, mem_q[dir_a_i], wr_ok, dir_wr_i, di_i);
      data_b_d = read_word(re_b_n_i, dir_b_i, mem_q[dir_b_i], wr_ok, dir_wr_i, di_i);
      if ((ZERO_REG != 0) && (probe_sel_i == '0))
        probe_d = '0;
      else
        probe_d = mem_q[probe_sel_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_CLEAR;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
      data_a_q <= '0;
      data_b_q <= '0;
      probe_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      probe_q  <= probe_d;
    end
  end

  // Storage is left untouched while reset is held; the clear sequence zeroes it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_we)
      mem_q[mem_waddr] <= mem_wdata;
  end

  assign data_a_o = data_a_q;
  assign data_b_o = data_b_q;
  assign probe_o  = probe_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_regfile_2r1w_param.sv
// Bench for regfile_2r1w_param: three instances (bypass, no bypass, zero-reg)
// share one stimulus and are checked every cycle against a behavioural model.
module tb_regfile_2r1w_param;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  dir_a_i, dir_b_i, dir_wr_i, probe_sel_i;
  logic        re_a_n_i, re_b_n_i, we_n_i;
  logic [31:0] di_i;

  logic [31:0] da [3];
  logic [31:0] db [3];
  logic [31:0] pr [3];
  logic        bz [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  // g=0: BYPASS=1 ZERO_REG=0, g=1: BYPASS=0 ZERO_REG=0, g=2: BYPASS=1 ZERO_REG=1
  for (genvar g = 0; g < 3; g++) begin : g_dut
    regfile_2r1w_param #(
      .WIDTH(32), .ADDR_W(4),
      .BYPASS((g == 1) ? 0 : 1),
      .ZERO_REG((g == 2) ? 1 : 0)
    ) u_dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .dir_a_i(dir_a_i), .dir_b_i(dir_b_i),
      .re_a_n_i(re_a_n_i), .re_b_n_i(re_b_n_i),
      .dir_wr_i(dir_wr_i), .di_i(di_i), .we_n_i(we_n_i),
      .probe_sel_i(probe_sel_i),
      .data_a_o(da[g]), .data_b_o(db[g]), .probe_o(pr[g]), .busy_o(bz[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: contents per instance, clear progress as a count of edges.
  logic [31:0] mm [3][16];
  logic [31:0] ea [3];
  logic [31:0] eb [3];
  logic [31:0] ep [3];
  bit          busy_m  = 1'b1;
  bit          started = 1'b0;
  int          cleared = 0;

  function automatic logic [31:0] model_read(input int k, input logic re_n, input logic [3:0] a,
                                             input bit wok);
    if (re_n) return 32'hFFFF_FFFF;
    if (k == 2 && a == 4'd0) return 32'h0;
    if (k != 1 && wok && dir_wr_i == a) return di_i;
    return mm[k][a];
  endfunction

  always @(posedge clk_i) begin
    if (rst_i) begin
      started = 1'b1;
      busy_m  = 1'b1;
      cleared = 0;
      for (int k = 0; k < 3; k++) begin
        ea[k] = 32'h0; eb[k] = 32'h0; ep[k] = 32'h0;
      end
    end else if (started && busy_m) begin
      for (int k = 0; k < 3; k++) begin
        mm[k][cleared] = 32'h0;
        ea[k] = 32'hFFFF_FFFF; eb[k] = 32'hFFFF_FFFF; ep[k] = 32'hFFFF_FFFF;
      end
      cleared++;
      if (cleared == 16) busy_m = 1'b0;
    end else if (started) begin
      for (int k = 0; k < 3; k++) begin
        bit wok;
        wok = !we_n_i && !(k == 2 && dir_wr_i == 4'd0);
        ea[k] = model_read(k, re_a_n_i, dir_a_i, wok);
        eb[k] = model_read(k, re_b_n_i, dir_b_i, wok);
        ep[k] = (k == 2 && probe_sel_i == 4'd0) ? 32'h0 : mm[k][probe_sel_i];
        if (wok) mm[k][dir_wr_i] = di_i;
      end
    end
  end

  always @(negedge clk_i) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("model data_a[%0d]", k), da[k], ea[k]);
        chk($sformatf("model data_b[%0d]", k), db[k], eb[k]);
        chk($sformatf("model probe[%0d]", k), pr[k], ep[k]);
        chk($sformatf("model busy[%0d]", k), {31'h0, bz[k]}, {31'h0, busy_m});
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    we_n_i = 1'b0; dir_wr_i = a; di_i = d;
    tick();
    we_n_i = 1'b1;
  endtask

  task automatic count_busy(input string nm);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (i == 0) chk({nm, " clear read all-ones"}, da[0], 32'hFFFF_FFFF);
      if (!bz[0]) break;
    end
    chk({nm, " busy edge count"}, n, 32'd16);
  endtask

  initial begin
    rst_i = 1'b1; we_n_i = 1'b1; re_a_n_i = 1'b0; re_b_n_i = 1'b0;
    dir_a_i = 4'd0; dir_b_i = 4'd0; dir_wr_i = 4'd0; probe_sel_i = 4'd0; di_i = 32'h0;
    tick(); tick();
    chk("reset data_a", da[0], 32'h0);
    chk("reset busy", {31'h0, bz[0]}, 32'h1);

    // Release reset with a write pending: it must be dropped during the clear.
    rst_i = 1'b0;
    we_n_i = 1'b0; dir_wr_i = 4'd4; di_i = 32'hDEAD_BEEF; dir_a_i = 4'd4;
    count_busy("clear1");
    we_n_i = 1'b1;

    for (int i = 0; i < 16; i++) begin
      dir_a_i = 4'(i); dir_b_i = 4'(15 - i); probe_sel_i = 4'(i);
      tick();
      chk("post-clear data_a zero", da[1], 32'h0);
    end

    wr(4'd1, 32'd1234);
    wr(4'd2, 32'd6545);
    wr(4'd3, 32'd8979);
    dir_a_i = 4'd1; dir_b_i = 4'd2; probe_sel_i = 4'd3;
    tick();
    chk("rw data_a", da[0], 32'd1234);
    chk("rw data_b", db[0], 32'd6545);
    chk("rw probe", pr[0], 32'd8979);

    re_a_n_i = 1'b1; dir_a_i = 4'd1; dir_b_i = 4'd1;
    tick();
    chk("re disable data_a", da[0], 32'hFFFF_FFFF);
    chk("re enable data_b", db[0], 32'd1234);
    re_a_n_i = 1'b0;

    wr(4'd5, 32'h11);
    we_n_i = 1'b0; dir_wr_i = 4'd5; di_i = 32'h22; dir_a_i = 4'd5;
    tick();
    we_n_i = 1'b1;
    chk("bypass on", da[0], 32'h22);
    chk("bypass off", da[1], 32'h11);
    tick();
    chk("bypass off next read", da[1], 32'h22);

    wr(4'd0, 32'hABCD);
    dir_a_i = 4'd0; probe_sel_i = 4'd0;
    tick();
    chk("zero_reg data_a", da[2], 32'h0);
    chk("zero_reg probe", pr[2], 32'h0);
    chk("normal reg0 data_a", da[0], 32'hABCD);

    // Mixed traffic: writes with concurrent reads on both ports and probe.
    for (int i = 0; i < 16; i++) begin
      we_n_i = i[0]; dir_wr_i = 4'(i); di_i = 32'h0101_0101 * i + 32'h5A;
      dir_a_i = 4'(i); dir_b_i = 4'(i - 1); probe_sel_i = 4'(15 - i);
      re_b_n_i = (i % 5 == 3);
      tick();
    end
    we_n_i = 1'b1; re_b_n_i = 1'b0;
    dir_a_i = 4'd7; dir_b_i = 4'd7;
    tick();
    chk("same-address A/B", db[0], da[0]);

    // Reset asserted partway through a clear restarts it from the beginning.
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    repeat (7) tick();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    count_busy("clear2");
    for (int i = 0; i < 16; i++) begin
      dir_a_i = 4'(i); dir_b_i = 4'(i); probe_sel_i = 4'(i);
      tick();
      chk("post-reclear data_a zero", da[0], 32'h0);
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
